// File: rtl/fft_pkg.sv
// Shared types and address math for the radix-2 DIT FFT
// butterfly address generator.
package fft_pkg;

  localparam int AW = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] tw;
  } bfly_addr_t;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  function automatic bfly_addr_t bfly_addr(
    input logic [AW-1:0] idx,
    input int            s,
    input int            lg
  );
    bfly_addr_t    r;
    logic [AW-1:0] h;
    logic [AW-1:0] pos;
    h    = AW'(1) << s;
    pos  = idx & (h - AW'(1));
    r.a  = ((idx >> s) << (s + 1)) | pos;
    r.b  = r.a + h;
    r.tw = pos << (lg - 1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Reset-clearable shift register; the MSB of each word is
// its valid bit, so pipe_empty reports no valid entry in flight.
module fft_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         pipe_empty
);

  logic [W-1:0] pipe_q [DEPTH];
  logic [W-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_q[i][W-1]) pipe_empty = 1'b0;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_bfly_addr_gen.sv
// Butterfly address generator and stage sequencer for an
// in-place radix-2 DIT FFT over bit-reversed input.
module fft_bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int N        = 16,
  parameter int BFLY_LAT = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         frame_start,
  input  logic [$clog2(N)-2:0]         bfly_idx,
  input  logic                         bfly_vld,
  output logic                         cnt_start,
  output logic                         rd_en,
  output logic [$clog2(N)-1:0]         rd_addr_a,
  output logic [$clog2(N)-1:0]         rd_addr_b,
  output logic [$clog2(N)-2:0]         tw_idx,
  output logic                         wr_en,
  output logic [$clog2(N)-1:0]         wr_addr_a,
  output logic [$clog2(N)-1:0]         wr_addr_b,
  output logic [$clog2($clog2(N))-1:0] stage,
  output logic                         busy,
  output logic                         done
);

  localparam int LOG2N = log2n(N);
  localparam int SW    = $clog2(LOG2N);
  localparam int DW    = 1 + 2 * LOG2N;
  localparam logic [SW-1:0] LAST = SW'(LOG2N - 1);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic             cnt_start_q, cnt_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             vld_q, vld_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_a_q, rd_a_d;
  logic [LOG2N-1:0] rd_b_q, rd_b_d;
  logic [LOG2N-2:0] tw_q, tw_d;

  bfly_addr_t ba;
  logic       pipe_empty;
  logic [DW-1:0] wb;
  logic       addr_unused;

  assign ba = bfly_addr(AW'(bfly_idx), int'(stage_q), LOG2N);
  // Upper bits are zero by construction at LOG2N-bit widths
  assign addr_unused = ^{ba.a[AW-1:LOG2N], ba.b[AW-1:LOG2N],
                         ba.tw[AW-1:LOG2N-1]};

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    busy_d      = busy_q;
    cnt_start_d = 1'b0;
    done_d      = 1'b0;
    vld_d       = 1'b0;
    rd_en_d     = 1'b0;
    rd_a_d      = '0;
    rd_b_d      = '0;
    tw_d        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          stage_d     = '0;
          cnt_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        vld_d = bfly_vld;
        if (bfly_vld) begin
          rd_en_d = 1'b1;
          rd_a_d  = ba.a[LOG2N-1:0];
          rd_b_d  = ba.b[LOG2N-1:0];
          tw_d    = ba.tw[LOG2N-2:0];
        end
        if (vld_q && !bfly_vld) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Next stage reads only after every write of this one
        if (pipe_empty && !rd_en_q) begin
          if (stage_q == LAST) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            stage_d     = stage_q + 1'b1;
            cnt_start_d = 1'b1;
            state_d     = S_RUN;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      cnt_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      tw_q        <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_start_q <= cnt_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      rd_en_q     <= rd_en_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      tw_q        <= tw_d;
    end
  end

  fft_delay_line #(
    .W     (DW),
    .DEPTH (BFLY_LAT)
  ) u_wb (
    .clk        (clk),
    .rstn       (rstn),
    .din        ({rd_en_q, rd_a_q, rd_b_q}),
    .dout       (wb),
    .pipe_empty (pipe_empty)
  );

  assign wr_en     = wb[DW-1];
  assign wr_addr_a = wb[2*LOG2N-1:LOG2N];
  assign wr_addr_b = wb[LOG2N-1:0];

  assign cnt_start = cnt_start_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_idx    = tw_q;
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Directed bench for fft_bfly_addr_gen at N=8, BFLY_LAT=2 with
// a behavioural model of the upstream stage counter.
module tb_fft_bfly_addr_gen;

  localparam int N   = 8;
  localparam int LAT = 2;

  localparam int EXP_A  [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
  localparam int EXP_B  [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
  localparam int EXP_TW [12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       frame_start;
  logic [1:0] bfly_idx;
  logic       bfly_vld;
  logic       cnt_start;
  logic       rd_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_idx;
  logic       wr_en;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;
  logic [1:0] stage;
  logic       busy;
  logic       done;

  logic       cvld = 1'b0;
  logic [1:0] cidx = '0;
  logic       crun = 1'b0;
  logic       spur_vld = 1'b0;
  logic [1:0] spur_idx = '0;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  cyc = 0;
  int  cs_n = 0;
  int  dn_n = 0;
  int  dn_cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  logic [22:0] all_out;

  assign bfly_vld = cvld | spur_vld;
  assign bfly_idx = spur_vld ? spur_idx : cidx;
  assign all_out  = {cnt_start, rd_en, rd_addr_a, rd_addr_b, tw_idx,
                     wr_en, wr_addr_a, wr_addr_b, stage, busy, done};

  always #5 clk = ~clk;

  fft_bfly_addr_gen #(
    .N        (N),
    .BFLY_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .bfly_idx    (bfly_idx),
    .bfly_vld    (bfly_vld),
    .cnt_start   (cnt_start),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .tw_idx      (tw_idx),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b),
    .stage       (stage),
    .busy        (busy),
    .done        (done)
  );

  // Upstream counter: N/2 consecutive indices after each start pulse
  always @(negedge clk) begin
    if (!rstn) begin
      crun = 1'b0;
      cvld = 1'b0;
    end else if (crun) begin
      if (cidx == 2'd3) begin
        crun = 1'b0;
        cvld = 1'b0;
      end else begin
        cidx = cidx + 2'd1;
      end
    end else if (cnt_start) begin
      crun = 1'b1;
      cvld = 1'b1;
      cidx = 2'd0;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    cyc = cyc + 1;
    if (rd_en) begin
      e = '{cyc, int'(rd_addr_a), int'(rd_addr_b), int'(tw_idx)};
      rd_q.push_back(e);
    end
    if (wr_en) begin
      e = '{cyc, int'(wr_addr_a), int'(wr_addr_b), 0};
      wr_q.push_back(e);
    end
    if (cnt_start) cs_n = cs_n + 1;
    if (done) begin
      dn_n   = dn_n + 1;
      dn_cyc = cyc;
    end
  end

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    cs_n = 0;
    dn_n = 0;
  endtask

  task automatic start_frame(input string nm);
    clear_logs();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({cnt_start, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL %s_start: cnt_start,busy=%b required 11",
               nm, {cnt_start, busy});
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dn_n != 0) break;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dn_n !== 1) begin
      n_err++;
      $display("FAIL %s_done_pulse: done cycles=%0d required 1", nm, dn_n);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_busy_end: busy=%b required 0", nm, busy);
    end
  endtask

  task automatic check_frame(input string nm);
    int nr;
    int nw;
    nr = (rd_q.size() < 12) ? rd_q.size() : 12;
    nw = (wr_q.size() < nr) ? wr_q.size() : nr;
    n_cmp++;
    if (rd_q.size() !== 12) begin
      n_err++;
      $display("FAIL %s_rd_count: got %0d required 12", nm, rd_q.size());
    end
    n_cmp++;
    if (wr_q.size() !== 12) begin
      n_err++;
      $display("FAIL %s_wr_count: got %0d required 12", nm, wr_q.size());
    end
    n_cmp++;
    if (cs_n !== 3) begin
      n_err++;
      $display("FAIL %s_cnt_start: got %0d required 3", nm, cs_n);
    end
    for (int i = 0; i < nr; i++) begin
      n_cmp++;
      if (rd_q[i].a !== EXP_A[i] || rd_q[i].b !== EXP_B[i] ||
          rd_q[i].tw !== EXP_TW[i]) begin
        n_err++;
        $display("FAIL %s_rd%0d: (a,b,tw)=(%0d,%0d,%0d) required (%0d,%0d,%0d)",
                 nm, i, rd_q[i].a, rd_q[i].b, rd_q[i].tw,
                 EXP_A[i], EXP_B[i], EXP_TW[i]);
      end
    end
    for (int i = 0; i < nw; i++) begin
      n_cmp++;
      if (wr_q[i].a !== EXP_A[i] || wr_q[i].b !== EXP_B[i] ||
          wr_q[i].cyc !== rd_q[i].cyc + LAT) begin
        n_err++;
        $display("FAIL %s_wr%0d: (a,b,dly)=(%0d,%0d,%0d) required (%0d,%0d,%0d)",
                 nm, i, wr_q[i].a, wr_q[i].b, wr_q[i].cyc - rd_q[i].cyc,
                 EXP_A[i], EXP_B[i], LAT);
      end
    end
    if (nw == 12) begin
      for (int k = 1; k < 3; k++) begin
        n_cmp++;
        if (rd_q[4*k].cyc <= wr_q[4*k-1].cyc) begin
          n_err++;
          $display("FAIL %s_stage_gap%0d: rd cyc %0d required after wr cyc %0d",
                   nm, k, rd_q[4*k].cyc, wr_q[4*k-1].cyc);
        end
      end
      n_cmp++;
      if (dn_cyc <= wr_q[11].cyc) begin
        n_err++;
        $display("FAIL %s_done_order: done cyc %0d required after %0d",
                 nm, dn_cyc, wr_q[11].cyc);
      end
    end
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    start_frame("frame");
    wait_done("frame");
    check_frame("frame");
  endtask

  task automatic test_ignore_restart();
    start_frame("restart");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stage == 2'd1 && rd_en) break;
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done("restart");
    check_frame("restart");
  endtask

  task automatic test_reset_mid();
    int nwr;
    start_frame("midrst");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_q.size() == 8 && !rd_en) break;
    end
    n_cmp++;
    if (stage !== 2'd1 || !busy) begin
      n_err++;
      $display("FAIL midrst_drain_pos: stage=%0d busy=%b required 1,1",
               stage, busy);
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    nwr = wr_q.size();
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %h required 0", all_out);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wr_q.size() !== nwr || rd_q.size() !== 8 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_quiet: wr %0d->%0d rd=%0d busy=%b required no change",
               nwr, wr_q.size(), rd_q.size(), busy);
    end
    start_frame("midrst_new");
    wait_done("midrst_new");
    check_frame("midrst_new");
  endtask

  task automatic test_spurious_vld();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      spur_vld = 1'b1;
      spur_idx = 2'(i);
    end
    @(negedge clk);
    spur_vld = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rd_q.size() !== 0 || wr_q.size() !== 0) begin
      n_err++;
      $display("FAIL spurious_io: rd=%0d wr=%0d required 0,0",
               rd_q.size(), wr_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0 || cs_n !== 0) begin
      n_err++;
      $display("FAIL spurious_state: busy=%b cnt_start=%0d required 0,0",
               busy, cs_n);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ignore_restart();
    test_reset_mid();
    test_spurious_vld();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
